// File: rtl/m2vside2_seq.sv
// Stage-2 side-information sequencer: expands one stage-1 macroblock into six
// 4:2:0 block records and tracks the macroblock position within the picture.
//
//   state | meaning
//   IDLE  | no record held, s2_enable low, waiting for a stage-1 macroblock
//   BLOCK | record for s2_block held on s2_*, advanced by each block_start
module m2vside2_seq #(
  parameter int MVH_WIDTH = 16,
  parameter int MVV_WIDTH = 15,
  parameter int MBX_WIDTH = 6,
  parameter int MBY_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pic_start,
  input  logic [MBX_WIDTH-1:0] pic_mb_width,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [MVH_WIDTH-1:0] s1_mv_h,
  input  logic [MVV_WIDTH-1:0] s1_mv_v,
  input  logic                 s1_mb_intra,
  input  logic [5:0]           s1_cbp,
  input  logic                 block_start,
  output logic [MVH_WIDTH-1:0] s2_mv_h,
  output logic [MVV_WIDTH-1:0] s2_mv_v,
  output logic [MBX_WIDTH-1:0] s2_mb_x,
  output logic [MBY_WIDTH-1:0] s2_mb_y,
  output logic                 s2_mb_intra,
  output logic [2:0]           s2_block,
  output logic                 s2_coded,
  output logic                 s2_enable
);

  typedef enum logic {IDLE = 1'b0, BLOCK = 1'b1} state_t;

  localparam logic [MBX_WIDTH-1:0] X_ONE = {{(MBX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MBY_WIDTH-1:0] Y_ONE = {{(MBY_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [MBX_WIDTH-1:0] pos_x_q, pos_x_d;
  logic [MBY_WIDTH-1:0] pos_y_q, pos_y_d;
  logic [MBX_WIDTH-1:0] width_q;
  logic [5:0]           cbp_q;
  logic [MVH_WIDTH-1:0] mv_h_q;
  logic [MVV_WIDTH-1:0] mv_v_q;
  logic [MBX_WIDTH-1:0] mb_x_q;
  logic [MBY_WIDTH-1:0] mb_y_q;
  logic                 intra_q;
  logic [2:0]           block_q;
  logic                 coded_q;
  logic                 enable_q;

  logic last_block;
  logic accept;
  logic next_cbp_bit;

  assign last_block = (state_q == BLOCK) && (block_q == 3'd5);
  assign s1_ready   = ~pic_start & ((state_q == IDLE) | (block_start & last_block));
  assign accept     = s1_valid & s1_ready;

  // Width 0 wraps at all-ones naturally, since width-1 underflows to all-ones.
  always_comb begin
    pos_x_d = pos_x_q + X_ONE;
    pos_y_d = pos_y_q;
    if (pos_x_q == (width_q - X_ONE)) begin
      pos_x_d = '0;
      pos_y_d = pos_y_q + Y_ONE;
    end
  end

  // cbp bit for the block that follows the current one (bit5 = block0).
  always_comb begin
    next_cbp_bit = 1'b0;
    case (block_q)
      3'd0:    next_cbp_bit = cbp_q[4];
      3'd1:    next_cbp_bit = cbp_q[3];
      3'd2:    next_cbp_bit = cbp_q[2];
      3'd3:    next_cbp_bit = cbp_q[1];
      3'd4:    next_cbp_bit = cbp_q[0];
      default: next_cbp_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      width_q  <= '0;
      cbp_q    <= '0;
      mv_h_q   <= '0;
      mv_v_q   <= '0;
      mb_x_q   <= '0;
      mb_y_q   <= '0;
      intra_q  <= 1'b0;
      block_q  <= '0;
      coded_q  <= 1'b0;
      enable_q <= 1'b0;
    end else if (pic_start) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      block_q  <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      width_q  <= pic_mb_width;
    end else if (accept) begin
      state_q  <= BLOCK;
      enable_q <= 1'b1;
      block_q  <= '0;
      mv_h_q   <= s1_mv_h;
      mv_v_q   <= s1_mv_v;
      intra_q  <= s1_mb_intra;
      cbp_q    <= s1_cbp;
      coded_q  <= s1_mb_intra | s1_cbp[5];
      mb_x_q   <= pos_x_q;
      mb_y_q   <= pos_y_q;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end else if ((state_q == BLOCK) && block_start) begin
      if (last_block) begin
        state_q  <= IDLE;
        enable_q <= 1'b0;
        block_q  <= '0;
      end else begin
        block_q <= block_q + 3'd1;
        coded_q <= intra_q | next_cbp_bit;
      end
    end
  end

  assign s2_mv_h     = mv_h_q;
  assign s2_mv_v     = mv_v_q;
  assign s2_mb_x     = mb_x_q;
  assign s2_mb_y     = mb_y_q;
  assign s2_mb_intra = intra_q;
  assign s2_block    = block_q;
  assign s2_coded    = coded_q;
  assign s2_enable   = enable_q;

endmodule
